// File: rtl/associative_cache_set_pkg.sv
// rtl/associative_cache_set_pkg.sv - shared helpers for the cache set
package associative_cache_set_pkg;

  function automatic int log(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/associative_cache_set_comparator.sv
// rtl/associative_cache_set_comparator.sv - per-way valid-gated tag compare
module associative_cache_set_comparator
  import associative_cache_set_pkg::*;
#(
  parameter int TAG_SIZE    = 14,
  parameter int WAY_NO_SIZE = 3,
  parameter int WAY         = 0
) (
  input  logic [TAG_SIZE-1:0]    tag_a_i,
  input  logic [TAG_SIZE-1:0]    tag_b_i,
  input  logic                   valid_i,
  output logic                   match_o,
  output logic [WAY_NO_SIZE-1:0] way_no_o
);

  assign match_o  = valid_i && (tag_a_i == tag_b_i);
  assign way_no_o = match_o ? WAY_NO_SIZE'(WAY) : '0;

endmodule

// File: rtl/associative_cache_set.sv
// rtl/associative_cache_set.sv - one N-way cache set with lookup, access and write-back
module associative_cache_set
  import associative_cache_set_pkg::*;
#(
  parameter int SET_INDEX        = 0,
  parameter int INDEX_SIZE       = 9,
  parameter int OFFSET_SIZE      = 6,
  parameter int TAG_SIZE         = 14,
  parameter int MAX_DATA_SIZE    = 64,
  parameter int MIN_ADDR_SIZE    = 8,
  parameter int NO_OF_WAYS       = 8,
  parameter int CACHE_BLOCK      = 512,
  parameter int MEM_ADDRESS_SIZE = 23,
  localparam int WAY_NO_SIZE     = log(NO_OF_WAYS),
  localparam int DSIZE_W         = log(MAX_DATA_SIZE) + 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable_signal,
  input  logic                           read,
  input  logic                           write,
  input  logic                           replace_block_in,
  input  logic [WAY_NO_SIZE-1:0]         way_no_in,
  input  logic [TAG_SIZE-1:0]            tag_in,
  input  logic [OFFSET_SIZE-1:0]         offset_in,
  input  logic [DSIZE_W-1:0]             data_size_in,
  input  logic [MAX_DATA_SIZE-1:0]       data_in,
  input  logic [CACHE_BLOCK-1:0]         block_data_in,
  output logic [NO_OF_WAYS*TAG_SIZE-1:0] tags_out,
  output logic [NO_OF_WAYS-1:0]          valid_bits_out,
  output logic [NO_OF_WAYS-1:0]          dirty_bits_out,
  output logic                           hit_out,
  output logic [WAY_NO_SIZE-1:0]         hit_way_out,
  output logic [MAX_DATA_SIZE-1:0]       data_out,
  output logic                           mem_write_out,
  output logic [MEM_ADDRESS_SIZE-1:0]    mem_address_out,
  output logic [CACHE_BLOCK-1:0]         block_data_out
);

  localparam int BLOCK_BYTES = CACHE_BLOCK / MIN_ADDR_SIZE;
  localparam int MAX_BYTES   = MAX_DATA_SIZE / MIN_ADDR_SIZE;
  localparam int SIZE_STEPS  = log(MAX_BYTES);
  localparam logic [INDEX_SIZE-1:0] SET_IDX = INDEX_SIZE'(SET_INDEX);

  logic [TAG_SIZE-1:0]         tags_q   [NO_OF_WAYS];
  logic [TAG_SIZE-1:0]         tags_d   [NO_OF_WAYS];
  logic [CACHE_BLOCK-1:0]      blocks_q [NO_OF_WAYS];
  logic [CACHE_BLOCK-1:0]      blocks_d [NO_OF_WAYS];
  logic [NO_OF_WAYS-1:0]       valid_q, valid_d, dirty_q, dirty_d;
  logic [MAX_DATA_SIZE-1:0]    data_q, data_d;
  logic                        mem_write_q, mem_write_d;
  logic [MEM_ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [CACHE_BLOCK-1:0]      mem_block_q, mem_block_d;

  logic [NO_OF_WAYS-1:0]  way_match;
  logic [WAY_NO_SIZE-1:0] way_code [NO_OF_WAYS];

  logic [CACHE_BLOCK-1:0]   blk;
  logic [MAX_DATA_SIZE-1:0] raw;
  logic                     sign, size_ok;
  int                       nbytes, idx;

  for (genvar g = 0; g < NO_OF_WAYS; g++) begin : g_cmp
    associative_cache_set_comparator #(
      .TAG_SIZE   (TAG_SIZE),
      .WAY_NO_SIZE(WAY_NO_SIZE),
      .WAY        (g)
    ) u_cmp (
      .tag_a_i (tags_q[g]),
      .tag_b_i (tag_in),
      .valid_i (valid_q[g]),
      .match_o (way_match[g]),
      .way_no_o(way_code[g])
    );
  end

  // Scan from the top so the lowest matching way wins
  always_comb begin
    hit_way_out = '0;
    for (int w = NO_OF_WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) hit_way_out = way_code[w];
    end
    hit_out = |way_match;
    for (int w = 0; w < NO_OF_WAYS; w++) tags_out[w*TAG_SIZE +: TAG_SIZE] = tags_q[w];
  end

  always_comb begin
    tags_d      = tags_q;
    blocks_d    = blocks_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    data_d      = data_q;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_block_d = '0;
    blk         = blocks_q[way_no_in];
    raw         = '0;
    sign        = 1'b0;
    idx         = 0;
    nbytes      = int'(data_size_in) / MIN_ADDR_SIZE;
    size_ok     = 1'b0;
    for (int k = 0; k <= SIZE_STEPS; k++) begin
      if (int'(data_size_in) == (MIN_ADDR_SIZE << k)) size_ok = 1'b1;
    end

    if (enable_signal) begin
      if (replace_block_in) begin
        if (valid_q[way_no_in] && dirty_q[way_no_in]) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {tags_q[way_no_in], SET_IDX};
          mem_block_d = blocks_q[way_no_in];
        end
        blk                = block_data_in;
        tags_d[way_no_in]  = tag_in;
        valid_d[way_no_in] = 1'b1;
        dirty_d[way_no_in] = 1'b0;
      end

      // Bytes beyond the end of the block read as zero and are dropped on write
      if (size_ok && read) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          idx = int'(offset_in) + i;
          if (i < nbytes && idx < BLOCK_BYTES)
            raw[i*MIN_ADDR_SIZE +: MIN_ADDR_SIZE] = blk[idx*MIN_ADDR_SIZE +: MIN_ADDR_SIZE];
        end
        for (int j = 0; j < MAX_DATA_SIZE; j++) begin
          if (j == int'(data_size_in) - 1) sign = raw[j];
        end
        for (int j = 0; j < MAX_DATA_SIZE; j++) begin
          if (j >= int'(data_size_in)) raw[j] = sign;
        end
        data_d = raw;
      end else if (size_ok && write) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          idx = int'(offset_in) + i;
          if (i < nbytes && idx < BLOCK_BYTES)
            blk[idx*MIN_ADDR_SIZE +: MIN_ADDR_SIZE] = data_in[i*MIN_ADDR_SIZE +: MIN_ADDR_SIZE];
        end
        dirty_d[way_no_in] = 1'b1;
      end

      blocks_d[way_no_in] = blk;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tags_q      <= '{default: '0};
      blocks_q    <= '{default: '0};
      valid_q     <= '0;
      dirty_q     <= '0;
      data_q      <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_block_q <= '0;
    end else begin
      tags_q      <= tags_d;
      blocks_q    <= blocks_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      data_q      <= data_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_block_q <= mem_block_d;
    end
  end

  assign valid_bits_out  = valid_q;
  assign dirty_bits_out  = dirty_q;
  assign data_out        = data_q;
  assign mem_write_out   = mem_write_q;
  assign mem_address_out = mem_addr_q;
  assign block_data_out  = mem_block_q;

endmodule

// File: tb/tb_associative_cache_set.sv
// tb/tb_associative_cache_set.sv - directed table-driven bench for associative_cache_set
module tb_associative_cache_set;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable_signal = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic         replace_block_in = 1'b0;
  logic [2:0]   way_no_in = '0;
  logic [13:0]  tag_in = '0;
  logic [5:0]   offset_in = '0;
  logic [6:0]   data_size_in = '0;
  logic [63:0]  data_in = '0;
  logic [511:0] block_data_in = '0;
  logic [111:0] tags_out;
  logic [7:0]   valid_bits_out, dirty_bits_out;
  logic         hit_out;
  logic [2:0]   hit_way_out;
  logic [63:0]  data_out;
  logic         mem_write_out;
  logic [22:0]  mem_address_out;
  logic [511:0] block_data_out;

  int total = 0;
  int bad = 0;

  associative_cache_set #(.SET_INDEX(5)) dut (
    .clock(clock), .reset_n(reset_n), .enable_signal(enable_signal),
    .read(read), .write(write), .replace_block_in(replace_block_in),
    .way_no_in(way_no_in), .tag_in(tag_in), .offset_in(offset_in),
    .data_size_in(data_size_in), .data_in(data_in), .block_data_in(block_data_in),
    .tags_out(tags_out), .valid_bits_out(valid_bits_out), .dirty_bits_out(dirty_bits_out),
    .hit_out(hit_out), .hit_way_out(hit_way_out), .data_out(data_out),
    .mem_write_out(mem_write_out), .mem_address_out(mem_address_out),
    .block_data_out(block_data_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rep, rd, wr;
    logic [5:0]  off;
    logic [6:0]  sz;
    logic [63:0] din;
    logic [63:0] exp_data;
    logic [7:0]  exp_valid, exp_dirty;
  } vec_t;

  vec_t vecs[16];
  logic [511:0] idx_blk, old_blk, exp_tags;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic op(input bit rep, input bit rd, input bit wr, input logic [2:0] way,
                    input logic [13:0] tag, input logic [5:0] off, input logic [6:0] sz,
                    input logic [63:0] din, input logic [511:0] blk);
    @(negedge clock);
    replace_block_in = rep; read = rd; write = wr; way_no_in = way; tag_in = tag;
    offset_in = off; data_size_in = sz; data_in = din; block_data_in = blk;
    enable_signal = 1'b1;
    @(posedge clock);
    #1;
    enable_signal = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) idx_blk[k*8 +: 8] = 8'(k);

    //        rep rd wr off    sz    din                exp_data                valid  dirty
    vecs[0]  = '{1, 0, 0, 6'h00, 7'd0,  64'h0,          64'h0,                  8'h08, 8'h00};
    vecs[1]  = '{0, 0, 1, 6'h3F, 7'd8,  64'hBF,         64'h0,                  8'h08, 8'h08};
    vecs[2]  = '{0, 1, 0, 6'h3E, 7'd16, 64'h0,          64'hFFFF_FFFF_FFFF_BF3E, 8'h08, 8'h08};
    vecs[3]  = '{0, 0, 1, 6'h04, 7'd32, 64'h1122_3344,  64'hFFFF_FFFF_FFFF_BF3E, 8'h08, 8'h08};
    vecs[4]  = '{0, 1, 0, 6'h00, 7'd64, 64'h0,          64'h1122_3344_0302_0100, 8'h08, 8'h08};
    vecs[5]  = '{0, 1, 0, 6'h05, 7'd8,  64'h0,          64'h33,                 8'h08, 8'h08};
    vecs[6]  = '{0, 1, 0, 6'h3E, 7'd32, 64'h0,          64'hBF3E,               8'h08, 8'h08};
    vecs[7]  = '{0, 1, 0, 6'h3F, 7'd8,  64'h0,          64'hFFFF_FFFF_FFFF_FFBF, 8'h08, 8'h08};
    vecs[8]  = '{0, 0, 1, 6'h3F, 7'd16, 64'h7755,       64'hFFFF_FFFF_FFFF_FFBF, 8'h08, 8'h08};
    vecs[9]  = '{0, 1, 0, 6'h3F, 7'd8,  64'h0,          64'h55,                 8'h08, 8'h08};
    vecs[10] = '{0, 1, 0, 6'h00, 7'd12, 64'h0,          64'h55,                 8'h08, 8'h08};
    vecs[11] = '{0, 0, 1, 6'h00, 7'd24, 64'hAA,         64'h55,                 8'h08, 8'h08};
    vecs[12] = '{0, 1, 0, 6'h00, 7'd8,  64'h0,          64'h00,                 8'h08, 8'h08};
    vecs[13] = '{0, 1, 1, 6'h01, 7'd8,  64'hEE,         64'h01,                 8'h08, 8'h08};
    vecs[14] = '{0, 1, 0, 6'h00, 7'd16, 64'h0,          64'h0100,               8'h08, 8'h08};
    vecs[15] = '{0, 1, 0, 6'h08, 7'd32, 64'h0,          64'h0B0A_0908,          8'h08, 8'h08};

    #12;
    check("rst valid", 512'(valid_bits_out), 512'h0);
    check("rst dirty", 512'(dirty_bits_out), 512'h0);
    check("rst data", 512'(data_out), 512'h0);
    check("rst mem_write", 512'(mem_write_out), 512'h0);
    check("rst mem_addr", 512'(mem_address_out), 512'h0);
    check("rst block_out", block_data_out, 512'h0);
    check("rst tags", 512'(tags_out), 512'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      op(vecs[i].rep, vecs[i].rd, vecs[i].wr, 3'd3, 14'h1A5, vecs[i].off, vecs[i].sz,
         vecs[i].din, idx_blk);
      check($sformatf("v%0d data", i), 512'(data_out), 512'(vecs[i].exp_data));
      check($sformatf("v%0d valid", i), 512'(valid_bits_out), 512'(vecs[i].exp_valid));
      check($sformatf("v%0d dirty", i), 512'(dirty_bits_out), 512'(vecs[i].exp_dirty));
      check($sformatf("v%0d hit", i), 512'({hit_out, hit_way_out}), 512'({1'b1, 3'd3}));
      check($sformatf("v%0d mem_write", i), 512'(mem_write_out), 512'h0);
    end

    // Dirty write-back on replacement, with a read of the freshly loaded block
    old_blk = idx_blk;
    old_blk[32 +: 32] = 32'h1122_3344;
    old_blk[63*8 +: 8] = 8'h55;
    op(1, 1, 0, 3'd3, 14'h002, 6'h00, 7'd8, 64'h0, {64{8'hC3}});
    check("wb strobe", 512'(mem_write_out), 512'h1);
    check("wb addr", 512'(mem_address_out), 512'({14'h1A5, 9'd5}));
    check("wb block", block_data_out, old_blk);
    check("wb read new", 512'(data_out), 512'(64'hFFFF_FFFF_FFFF_FFC3));
    check("wb dirty", 512'(dirty_bits_out), 512'h0);
    check("wb tag3", 512'(tags_out[42 +: 14]), 512'h2);
    check("wb hit", 512'({hit_out, hit_way_out}), 512'({1'b1, 3'd3}));
    @(posedge clock);
    #1;
    check("wb strobe end", 512'(mem_write_out), 512'h0);
    check("wb addr idle", 512'(mem_address_out), 512'h0);
    check("wb block idle", block_data_out, 512'h0);

    // Replacement of an invalid way combined with a write
    op(1, 0, 1, 3'd1, 14'h007, 6'h00, 7'd8, 64'h99, 512'h0);
    check("rw no strobe", 512'(mem_write_out), 512'h0);
    check("rw valid", 512'(valid_bits_out), 512'h0A);
    check("rw dirty", 512'(dirty_bits_out), 512'h02);
    op(0, 1, 0, 3'd1, 14'h007, 6'h00, 7'd8, 64'h0, 512'h0);
    check("rw read", 512'(data_out), 512'(64'hFFFF_FFFF_FFFF_FF99));

    // Two ways with the same tag: lowest index reported
    op(1, 0, 0, 3'd5, 14'h007, 6'h00, 7'd0, 64'h0, 512'h0);
    check("multi valid", 512'(valid_bits_out), 512'h2A);
    check("multi hit", 512'({hit_out, hit_way_out}), 512'({1'b1, 3'd1}));
    exp_tags = '0;
    exp_tags[1*14 +: 14] = 14'h007;
    exp_tags[3*14 +: 14] = 14'h002;
    exp_tags[5*14 +: 14] = 14'h007;
    check("tags_out", 512'(tags_out), exp_tags);
    @(negedge clock);
    tag_in = 14'h003;
    #1;
    check("miss", 512'({hit_out, hit_way_out}), 512'h0);

    // Disabled edge leaves everything alone
    @(negedge clock);
    read = 1'b1; write = 1'b0; replace_block_in = 1'b1; way_no_in = 3'd1;
    offset_in = 6'h0; data_size_in = 7'd64; enable_signal = 1'b0;
    @(posedge clock);
    #1;
    check("dis data", 512'(data_out), 512'(64'hFFFF_FFFF_FFFF_FF99));
    check("dis valid", 512'(valid_bits_out), 512'h2A);
    check("dis dirty", 512'(dirty_bits_out), 512'h02);
    check("dis strobe", 512'(mem_write_out), 512'h0);

    // Reset right after a write-back edge kills the strobe
    op(1, 0, 0, 3'd1, 14'h009, 6'h00, 7'd0, 64'h0, 512'h0);
    check("rs strobe up", 512'(mem_write_out), 512'h1);
    reset_n = 1'b0;
    #1;
    check("rs strobe", 512'(mem_write_out), 512'h0);
    check("rs addr", 512'(mem_address_out), 512'h0);
    check("rs valid", 512'(valid_bits_out), 512'h0);
    check("rs data", 512'(data_out), 512'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
